shift_unit_sequencer: RTL and testbench
=======================================

Name: shift_unit_sequencer

Overview:
- Shares one 32-bit left-logical barrel shifter (shift_left_logic, combinational) between two requesters.
- Requesters are the ALU shift path (req0) and the immediate/LUI path (req1).
- The block arbitrates round-robin and drives the shifter operands from registers.
- It synthesizes SRL, and optionally SRA, by bit-reversal around the left shifter, using a second shifter pass where needed. Each result is returned through a valid/ready response port.

Parameters:
- WIDTH, 32, datapath width. Fixed to 32 because it must match the shifter.
- RR_INIT, 1, reset value of last_grant, so req0 wins the first contention.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- req0_valid  in  1  requester 0 has an operation.
- req0_ready  out  1  requester 0 accepted this cycle.
- req0_op  in  2  00 SLL, 01 SRL, 10 SRA, 11 illegal.
- req0_data  in  32  value to shift.
- req0_amt  in  32  shift amount; the full 32 bits are significant.
- req1_valid / req1_ready / req1_op / req1_data / req1_amt: same as req0 for requester 1.
- resp_valid  out  1  result available.
- resp_ready  in  1  consumer takes the result.
- resp_id  out  1  0 = req0, 1 = req1.
- resp_data  out  32  shifted result.
- resp_err  out  1  illegal or disabled op.
- sh_a  out  32  shifter data operand.
- sh_b  out  32  shifter amount operand.
- sh_out  in  32  shifter result (combinational from sh_a/sh_b).

Behaviour:
- Reset: all of the following reset to 0 on the rising clk edge with rst_n=0:
  - outputs resp_valid, resp_id, resp_data, resp_err, sh_a, sh_b, req0_ready, req1_ready;
  - state = IDLE;
  - last_grant = RR_INIT.
- A reset mid-operation drops any in-flight or held response.
- FSM states: IDLE, PASS1, PASS2, HOLD.
- IDLE:
  - reqN_ready = grantN, a combinational function of the valids and last_grant.
  - If exactly one requester is valid, it is granted. If both are valid, grant the one that is not last_grant.
  - On grant: latch op, data, amt and id; update last_grant; go to PASS1.
  - A requester's ready is never 1 outside IDLE.
- PASS1:
  - sh_a = (op==SLL) ? data : bitrev(data); sh_b = amt.
  - Capture r1 = (op==SLL) ? sh_out : bitrev(sh_out).
  - If op is SRA and the feature is enabled, go to PASS2; otherwise go to HOLD.
- PASS2 (SRA only):
  - sh_a = 32'hFFFF_FFFF; sh_b = amt.
  - mask = ~bitrev(sh_out), i.e. ones in the top min(amt,32) bits.
  - result = r1 | (data[31] ? mask : 0). Go to HOLD.
- HOLD:
  - resp_valid = 1; resp_data, resp_id and resp_err are stable.
  - On resp_valid & resp_ready, go to IDLE.
- Outside PASS1/PASS2, sh_a and sh_b are held at 0.
- Latency, with acceptance at cycle T:
  - resp_valid rises at T+2 for SLL/SRL, T+3 for SRA.
  - Throughput is one operation per 3 (or 4) cycles when the consumer is always ready.
- amt >= 32 (any of bits 31:5 set):
  - the shifter yields 0, so SLL/SRL produce 0;
  - SRA produces 32'hFFFF_FFFF if data[31] = 1, else 0.
- Illegal op (11, or 10 without the feature):
  - no shifter pass; go from IDLE directly to PASS1, then HOLD;
  - resp_data = 0, resp_err = 1.
- No simultaneous accept and response: a new request is accepted only in the cycle after the HOLD handshake.

Optional Feature:
- Macro SHIFT_SEQ_SRA_EN.
- Defined: op 10 performs SRA using the two-pass flow above.
- Undefined: the PASS2 state and mask logic are absent; op 10 is treated as illegal (resp_err = 1, resp_data = 0, latency T+2).

Decomposition:
- Package shift_seq_pkg holds:
  - op encodings SHOP_SLL/SRL/SRA/ILL;
  - the state enum;
  - WIDTH constant;
  - a bitrev function.
- One natural sub-module: shift_seq_rr_arb, the 2-way round-robin arbiter. Inputs: valids and last_grant. Outputs: one-hot grant.
- The shifter itself stays external and is connected through sh_a/sh_b/sh_out.

Test Plan:
- req0 SLL, data 0x0000_0001, amt 4, resp_ready = 1: resp_valid at T+2, resp_data 0x0000_0010, resp_id 0, resp_err 0.
- req1 SRL, data 0x8000_0000, amt 31: resp_data 0x0000_0001. Repeat with amt 0x20: resp_data 0.
- SRA, data 0xF000_0000, amt 4 (with SHIFT_SEQ_SRA_EN): resp at T+3, resp_data 0xFF00_0000. Repeat with amt 0x100: resp_data 0xFFFF_FFFF.
- Both valid continuously after reset: grants alternate 0,1,0,1. resp_id follows the same order; no requester is granted twice in a row.
- resp_ready held low for 5 cycles in HOLD: resp_data and resp_id stay stable, both readies stay 0. After the handshake, a new accept occurs the next cycle.
- rst_n pulsed low during PASS1: next cycle state IDLE, resp_valid 0, pending result discarded. Op 11: resp_err 1, resp_data 0.

Source files
------------

// File: rtl/shift_seq_pkg.sv
// shift_seq_pkg: op codes, FSM states and helpers for shift_unit_sequencer (SRA gated by SHIFT_SEQ_SRA_EN)
package shift_seq_pkg;
  localparam int WIDTH = 32;
  localparam logic [1:0] SHOP_SLL = 2'b00;
  localparam logic [1:0] SHOP_SRL = 2'b01;
  localparam logic [1:0] SHOP_SRA = 2'b10;
  localparam logic [1:0] SHOP_ILL = 2'b11;
  typedef enum logic [1:0] {IDLE, PASS1, PASS2, HOLD} state_t;
  function automatic logic [WIDTH-1:0] bitrev(input logic [WIDTH-1:0] x);
    for (int i = 0; i < WIDTH; i++) bitrev[i] = x[WIDTH-1-i];
  endfunction
  function automatic logic op_ill(input logic [1:0] op);
`ifdef SHIFT_SEQ_SRA_EN
    op_ill = op == SHOP_ILL;
`else
    op_ill = op[1];
`endif
  endfunction
endpackage

// File: rtl/shift_seq_rr_arb.sv
// shift_seq_rr_arb: two-way round-robin arbiter producing a one-hot grant
module shift_seq_rr_arb
  import shift_seq_pkg::*;
(
  input  logic [1:0] valid,
  input  logic       last_grant,
  output logic [1:0] grant
);
  assign grant[0] = valid[0] & (~valid[1] | last_grant);
  assign grant[1] = valid[1] & (~valid[0] | ~last_grant);
endmodule

// File: rtl/shift_unit_sequencer.sv
// shift_unit_sequencer: shares an external left shifter between two requesters, SLL/SRL (SRA with SHIFT_SEQ_SRA_EN)
module shift_unit_sequencer #(
  parameter int WIDTH   = 32,
  parameter bit RR_INIT = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [1:0]       req0_op,
  input  logic [WIDTH-1:0] req0_data,
  input  logic [WIDTH-1:0] req0_amt,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [1:0]       req1_op,
  input  logic [WIDTH-1:0] req1_data,
  input  logic [WIDTH-1:0] req1_amt,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic             resp_id,
  output logic [WIDTH-1:0] resp_data,
  output logic             resp_err,
  output logic [WIDTH-1:0] sh_a,
  output logic [WIDTH-1:0] sh_b,
  input  logic [WIDTH-1:0] sh_out
);
  import shift_seq_pkg::*;
  state_t           state;
  logic             last_grant;
  logic             id_q;
  logic [1:0]       op_q;
  logic [1:0]       grant;
  logic [1:0]       sel_op;
  logic [WIDTH-1:0] sel_data;
  logic [WIDTH-1:0] sel_amt;
`ifdef SHIFT_SEQ_SRA_EN
  logic             sign_q;
  logic [WIDTH-1:0] amt_q;
`endif
  shift_seq_rr_arb u_arb (
    .valid      ({req1_valid, req0_valid}),
    .last_grant (last_grant),
    .grant      (grant)
  );
  assign req0_ready = rst_n && state == IDLE && grant[0];
  assign req1_ready = rst_n && state == IDLE && grant[1];
  assign sel_op   = grant[1] ? req1_op   : req0_op;
  assign sel_data = grant[1] ? req1_data : req0_data;
  assign sel_amt  = grant[1] ? req1_amt  : req0_amt;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      last_grant <= RR_INIT;
      id_q       <= 1'b0;
      op_q       <= SHOP_SLL;
      resp_valid <= 1'b0;
      resp_id    <= 1'b0;
      resp_data  <= '0;
      resp_err   <= 1'b0;
      sh_a       <= '0;
      sh_b       <= '0;
`ifdef SHIFT_SEQ_SRA_EN
      sign_q     <= 1'b0;
      amt_q      <= '0;
`endif
    end else begin
      case (state)
        IDLE: if (|grant) begin
          id_q       <= grant[1];
          last_grant <= grant[1];
          op_q       <= sel_op;
          sh_a       <= op_ill(sel_op) ? '0 : sel_op == SHOP_SLL ? sel_data : bitrev(sel_data);
          sh_b       <= op_ill(sel_op) ? '0 : sel_amt;
`ifdef SHIFT_SEQ_SRA_EN
          sign_q     <= sel_data[WIDTH-1];
          amt_q      <= sel_amt;
`endif
          state      <= PASS1;
        end
        PASS1: begin
          resp_data <= op_ill(op_q) ? '0 : op_q == SHOP_SLL ? sh_out : bitrev(sh_out);
          resp_err  <= op_ill(op_q);
          resp_id   <= id_q;
`ifdef SHIFT_SEQ_SRA_EN
          sh_a       <= op_q == SHOP_SRA ? '1 : '0;
          sh_b       <= op_q == SHOP_SRA ? amt_q : '0;
          resp_valid <= op_q != SHOP_SRA;
          state      <= op_q == SHOP_SRA ? PASS2 : HOLD;
`else
          sh_a       <= '0;
          sh_b       <= '0;
          resp_valid <= 1'b1;
          state      <= HOLD;
`endif
        end
`ifdef SHIFT_SEQ_SRA_EN
        PASS2: begin
          resp_data  <= resp_data | (sign_q ? ~bitrev(sh_out) : '0);
          sh_a       <= '0;
          sh_b       <= '0;
          resp_valid <= 1'b1;
          state      <= HOLD;
        end
`endif
        HOLD: if (resp_ready) begin
          resp_valid <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_shift_unit_sequencer.sv
// tb_shift_unit_sequencer: directed self-checking bench for shift_unit_sequencer
module tb_shift_unit_sequencer;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic        req0_ready, req1_ready;
  logic [1:0]  req0_op = 2'b00, req1_op = 2'b00;
  logic [31:0] req0_data = '0, req1_data = '0, req0_amt = '0, req1_amt = '0;
  logic        resp_valid, resp_ready = 1'b1, resp_id, resp_err;
  logic [31:0] resp_data, sh_a, sh_b, sh_out;
  int          checks = 0;
  int          errors = 0;
  always #5 clk = ~clk;
  assign sh_out = (|sh_b[31:5]) ? 32'h0 : sh_a << sh_b[4:0];
  shift_unit_sequencer dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op), .req0_data(req0_data), .req0_amt(req0_amt),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op), .req1_data(req1_data), .req1_amt(req1_amt),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id), .resp_data(resp_data), .resp_err(resp_err),
    .sh_a(sh_a), .sh_b(sh_b), .sh_out(sh_out)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic drive(input bit id, input logic [1:0] op, input logic [31:0] d, input logic [31:0] a);
    if (id) begin
      req1_valid = 1'b1; req1_op = op; req1_data = d; req1_amt = a;
    end else begin
      req0_valid = 1'b1; req0_op = op; req0_data = d; req0_amt = a;
    end
  endtask
  task automatic wait_resp(output int n);
    n = 0;
    while (!resp_valid && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
  endtask
  task automatic run_op(input string tag, input bit id, input logic [1:0] op, input logic [31:0] d,
                        input logic [31:0] a, input logic [31:0] exp_d, input bit exp_e, input int exp_lat);
    int n;
    @(negedge clk);
    drive(id, op, d, a);
    #1 chk({tag, "_ready"}, id ? req1_ready : req0_ready, 1);
    @(posedge clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    wait_resp(n);
    chk({tag, "_latency"}, n, exp_lat);
    chk({tag, "_data"}, resp_data, exp_d);
    chk({tag, "_id"}, resp_id, id);
    chk({tag, "_err"}, resp_err, exp_e);
    @(posedge clk); #1;
    chk({tag, "_done"}, resp_valid, 0);
  endtask
  initial begin
    int n;
    int g[$];
    int gc[$];
    int ids[$];
    req0_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready0", req0_ready, 0);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_resp_data", resp_data, 0);
    chk("rst_resp_id", resp_id, 0);
    chk("rst_resp_err", resp_err, 0);
    chk("rst_sh_a", sh_a, 0);
    chk("rst_sh_b", sh_b, 0);
    req0_valid = 1'b0;
    rst_n = 1'b1;
    run_op("sll", 0, 2'b00, 32'h0000_0001, 32'd4, 32'h0000_0010, 0, 1);
    run_op("srl31", 1, 2'b01, 32'h8000_0000, 32'd31, 32'h0000_0001, 0, 1);
    run_op("srl32", 1, 2'b01, 32'h8000_0000, 32'h20, 32'h0, 0, 1);
    run_op("sll_big", 0, 2'b00, 32'hFFFF_FFFF, 32'h8000_0001, 32'h0, 0, 1);
    run_op("srl7", 0, 2'b01, 32'h1234_5678, 32'd7, 32'h0024_68AC, 0, 1);
`ifdef SHIFT_SEQ_SRA_EN
    run_op("sra4", 1, 2'b10, 32'hF000_0000, 32'd4, 32'hFF00_0000, 0, 2);
    run_op("sra_big", 0, 2'b10, 32'hF000_0000, 32'h100, 32'hFFFF_FFFF, 0, 2);
    run_op("sra_pos", 0, 2'b10, 32'h7000_0000, 32'd4, 32'h0700_0000, 0, 2);
    run_op("sra0", 1, 2'b10, 32'h8000_0001, 32'd0, 32'h8000_0001, 0, 2);
`else
    run_op("sra_off", 1, 2'b10, 32'hF000_0000, 32'd4, 32'h0, 1, 1);
`endif
    run_op("ill", 0, 2'b11, 32'hDEAD_BEEF, 32'd3, 32'h0, 1, 1);
    // contention right after reset: req0 first, then strict alternation
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    drive(0, 2'b00, 32'h1, 32'd1);
    drive(1, 2'b00, 32'h1, 32'd2);
    for (int i = 0; i < 24; i++) begin
      #1;
      if (req0_ready) begin g.push_back(0); gc.push_back(i); end
      if (req1_ready) begin g.push_back(1); gc.push_back(i); end
      if (resp_valid) ids.push_back(int'(resp_id));
      @(negedge clk);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    chk("alt_count", (g.size() >= 4 && ids.size() >= 4) ? 1 : 0, 1);
    if (g.size() >= 4 && ids.size() >= 4) begin
      chk("alt_g0", g[0], 0);
      chk("alt_g1", g[1], 1);
      chk("alt_g2", g[2], 0);
      chk("alt_g3", g[3], 1);
      chk("alt_id0", ids[0], 0);
      chk("alt_id1", ids[1], 1);
      chk("alt_id2", ids[2], 0);
      chk("alt_id3", ids[3], 1);
      chk("alt_gap", gc[1] - gc[0], 3);
      for (int i = 1; i < g.size(); i++) chk("alt_no_repeat", (g[i] != g[i-1]) ? 1 : 0, 1);
    end
    repeat (6) @(posedge clk);
    // consumer stalls in HOLD while the other requester waits
    @(negedge clk);
    resp_ready = 1'b0;
    drive(0, 2'b00, 32'h3, 32'd1);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    drive(1, 2'b00, 32'h5, 32'd2);
    wait_resp(n);
    chk("bp_latency", n, 1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_valid", resp_valid, 1);
      chk("bp_data", resp_data, 32'h6);
      chk("bp_id", resp_id, 0);
      chk("bp_ready", {30'b0, req1_ready, req0_ready}, 0);
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_release", resp_valid, 0);
    chk("bp_next_accept", req1_ready, 1);
    @(posedge clk); #1;
    req1_valid = 1'b0;
    wait_resp(n);
    chk("bp2_data", resp_data, 32'h14);
    chk("bp2_id", resp_id, 1);
    @(posedge clk); #1;
    // reset while in PASS1 discards the operation
    @(negedge clk);
    drive(0, 2'b00, 32'h1, 32'd1);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("mid_rst_valid", resp_valid, 0);
    chk("mid_rst_sh_a", sh_a, 0);
    chk("mid_rst_sh_b", sh_b, 0);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("mid_rst_discard", resp_valid, 0);
    run_op("post_rst_ill", 1, 2'b11, 32'h1, 32'd1, 32'h0, 1, 1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
